// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard for the in-order pipeline: tracks in-flight destinations, stalls on load-use,
// forwards operands per source port. Define SCOREBOARD_WB_BYPASS_EN to forward from writeback.

module pipe_scoreboard_port #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2
) (
    input  logic [DEPTH-1:0]           i_vld,
    input  logic [DEPTH-1:0]           i_ld,
    input  logic [DEPTH-1:0][4:0]      i_rd,
    input  logic [4:0]                 i_src,
    input  logic                       i_used,
    input  logic [DEPTH-1:0][XLEN-1:0] i_data,
    output logic                       o_hazard,
    output logic                       o_hit,
    output logic [XLEN-1:0]            o_data
);

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic WB_HAZ = 1'b0;
`else
    localparam logic WB_HAZ = 1'b1;
`endif

    logic            w_match;
    logic            w_haz;
    logic [XLEN-1:0] w_data;

    always_comb begin
        w_match = 1'b0;
        w_haz   = 1'b0;
        w_data  = '0;
        // Walk oldest to youngest so the youngest producer overwrites older matches.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_used && (i_src != 5'd0) && i_vld[i] && (i_rd[i] == i_src)) begin
                w_match = 1'b1;
                w_haz   = (i_ld[i] && (i < LOAD_READY)) || (WB_HAZ && (i == DEPTH - 1));
                w_data  = i_data[i];
            end
        end
    end

    assign o_hazard = w_haz;
    assign o_hit    = w_match & ~w_haz;
    assign o_data   = o_hit ? w_data : '0;

endmodule

module pipe_scoreboard #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_READY = 2,
    parameter int CNTW       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_issue_valid,
    input  logic                   i_issue_we,
    input  logic                   i_issue_is_load,
    input  logic [4:0]             i_issue_rd,
    input  logic [NSRC*5-1:0]      i_src_addr,
    input  logic [NSRC-1:0]        i_src_used,
    input  logic                   i_flush,
    input  logic [DEPTH*XLEN-1:0]  i_stage_data,
    output logic                   o_stall,
    output logic [NSRC-1:0]        o_fwd_hit,
    output logic [NSRC*XLEN-1:0]   o_fwd_data,
    output logic [CNTW-1:0]        o_stall_cycles
);

    logic [DEPTH-1:0]           r_vld;
    logic [DEPTH-1:0]           r_ld;
    logic [DEPTH-1:0][4:0]      r_rd;
    logic [CNTW-1:0]            r_cnt;

    logic [DEPTH-1:0][XLEN-1:0] w_stage;
    logic [NSRC-1:0]            w_haz;
    logic                       w_stall;
    logic                       w_push;

    assign w_stage = i_stage_data;

    genvar k;
    generate
        for (k = 0; k < NSRC; k++) begin : g_port
            pipe_scoreboard_port #(
                .XLEN       (XLEN),
                .DEPTH      (DEPTH),
                .LOAD_READY (LOAD_READY)
            ) u_port (
                .i_vld    (r_vld),
                .i_ld     (r_ld),
                .i_rd     (r_rd),
                .i_src    (i_src_addr[5*k +: 5]),
                .i_used   (i_src_used[k]),
                .i_data   (w_stage),
                .o_hazard (w_haz[k]),
                .o_hit    (o_fwd_hit[k]),
                .o_data   (o_fwd_data[XLEN*k +: XLEN])
            );
        end
    endgenerate

    // Flush discards the issue anyway, so it overrides any hazard.
    assign w_stall = (|w_haz) & ~i_flush;
    assign w_push  = i_issue_valid & ~w_stall & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            r_ld  <= '0;
            r_rd  <= '0;
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_ld[i]  <= r_ld[i-1];
                r_rd[i]  <= r_rd[i-1];
            end
            r_vld[0] <= w_push & i_issue_we;
            r_ld[0]  <= w_push & i_issue_is_load;
            r_rd[0]  <= w_push ? i_issue_rd : 5'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stall        = w_stall;
    assign o_stall_cycles = r_cnt;

endmodule
